// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store memory stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lsu_pkg;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-enable patterns on the 32-bit data bus
  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_LO_H = 4'b0011;
  localparam logic [3:0] BE_HI_H = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory bus between the load/store stage and memory.
// Latency: n/a (wires only).
// Backpressure: req is held until gnt; read data arrives later on rvalid.
interface lsu_mem_stage_if #(parameter int AW = 32);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          gnt;
  logic          rvalid;
  logic [31:0]   rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering, access legality and load extension for a 32-bit bus.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
  import lsu_pkg::*;
(
  // request side: the access being started this cycle
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  output logic        req_legal,
  output logic [3:0]  req_be,
  output logic [31:0] req_lane,
  // response side: the load whose word is returning
  input  logic [2:0]  rsp_funct3,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rsp_word,
  output logic [31:0] rsp_data
);

  logic [31:0] shifted;

  // Legality: known funct3 for the direction, natural alignment for h/w
  always_comb begin
    req_legal = 1'b0;
    case (req_funct3)
      F3_B:    req_legal = 1'b1;
      F3_H:    req_legal = ~req_off[0];
      F3_W:    req_legal = (req_off == 2'b00);
      F3_BU:   req_legal = ~req_we;
      F3_HU:   req_legal = ~req_we & ~req_off[0];
      default: req_legal = 1'b0;
    endcase
  end

  // Store lanes: replicate the datum so every enabled lane sees it; loads read the whole word
  always_comb begin
    req_be   = BE_ALL;
    req_lane = req_wdata;
    if (req_we) begin
      case (req_funct3)
        F3_B: begin
          req_be   = BE_B0 << req_off;
          req_lane = {4{req_wdata[7:0]}};
        end
        F3_H: begin
          req_be   = req_off[1] ? BE_HI_H : BE_LO_H;
          req_lane = {2{req_wdata[15:0]}};
        end
        F3_W:    req_be = BE_ALL;
        default: req_be = BE_NONE;
      endcase
    end
  end

  // Load extract: bring the addressed byte/half to bit 0, then extend
  always_comb begin
    shifted  = rsp_word >> {rsp_off, 3'b000};
    rsp_data = rsp_word;
    case (rsp_funct3)
      F3_B:    rsp_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rsp_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rsp_data = {24'h000000, shifted[7:0]};
      F3_HU:   rsp_data = {16'h0000, shifted[15:0]};
      default: rsp_data = rsp_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store stage: one data-memory transaction per start, extended load data to writeback.
// Latency: store 2 + gnt wait; load 2 + gnt wait + rvalid wait (min 3); rejected access 1.
// Backpressure: busy stalls the core from the start cycle until the response cycle.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int AW = 32
)
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mem_we,
  input  logic [2:0]      mem_funct3,
  input  logic [AW-1:0]   addr,
  input  logic [31:0]     wdata,
  output logic            busy,
  output logic            done,
  output logic [31:0]     rdata,
  output logic            err,
  lsu_mem_stage_if.master bus
);

  state_t        state_q, state_d;
  logic          can_start;
  logic          accept, reject, capture;

  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic          err_q;
  logic [31:0]   rdata_q;
  logic [AW-1:0] addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;

  logic          legal;
  logic [3:0]    be_d;
  logic [31:0]   lane_d;
  logic [31:0]   ld_data;

  lsu_align u_align (
    .req_we     (mem_we),
    .req_funct3 (mem_funct3),
    .req_off    (addr[1:0]),
    .req_wdata  (wdata),
    .req_legal  (legal),
    .req_be     (be_d),
    .req_lane   (lane_d),
    .rsp_funct3 (f3_q),
    .rsp_off    (off_q),
    .rsp_word   (bus.rdata),
    .rsp_data   (ld_data)
  );

  // A new access may only begin when no transaction is outstanding
  assign can_start = (state_q == IDLE) || (state_q == RESP);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state; starts during REQ/WAIT and stray gnt/rvalid are ignored
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (start) begin
          if (legal) begin
            state_d = REQ;
            accept  = 1'b1;
          end else begin
            state_d = RESP;
            reject  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (bus.gnt) state_d = we_q ? RESP : WAIT;
      end
      WAIT: begin
        if (bus.rvalid) begin
          state_d = RESP;
          capture = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields latch at accept and stay stable through REQ; load data registers on rvalid
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      addr_q  <= '0;
      be_q    <= BE_NONE;
      wdata_q <= 32'h0;
    end else begin
      if (accept) begin
        we_q    <= mem_we;
        f3_q    <= mem_funct3;
        off_q   <= addr[1:0];
        err_q   <= 1'b0;
        addr_q  <= {addr[AW-1:2], 2'b00};
        be_q    <= be_d;
        wdata_q <= lane_d;
      end
      if (reject) begin
        err_q   <= 1'b1;
        rdata_q <= 32'h0;
      end
      if (capture) rdata_q <= ld_data;
    end
  end

  assign busy  = (state_q == REQ) || (state_q == WAIT) || (start && can_start);
  assign done  = (state_q == RESP);
  assign err   = (state_q == RESP) && err_q;
  assign rdata = rdata_q;

  assign bus.req   = (state_q == REQ);
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.be    = be_q;
  assign bus.wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for the load/store stage with a hand-timed memory on the bus.
// Latency: n/a.
// Backpressure: gnt and rvalid are driven per scenario.
module tb_lsu_mem_stage;
  import lsu_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  int pass_cnt;
  int total_cnt;
  int done_cnt;

  lsu_mem_stage_if #(.AW(32)) bus_if ();

  lsu_mem_stage #(.AW(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_we     (mem_we),
    .mem_funct3 (mem_funct3),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .err        (err),
    .bus        (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count completion pulses independently of the scenario tasks
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass_cnt++;
    total_cnt++; if (bus_if.req !== 1'b0) $display("FAIL reset_req got %b want 0", bus_if.req); else pass_cnt++;
    total_cnt++; if (bus_if.we !== 1'b0) $display("FAIL reset_we got %b want 0", bus_if.we); else pass_cnt++;
    total_cnt++; if (bus_if.be !== 4'b0000) $display("FAIL reset_be got %b want 0000", bus_if.be); else pass_cnt++;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", rdata); else pass_cnt++;
    total_cnt++; if (bus_if.addr !== 32'h0) $display("FAIL reset_addr got %h want 0", bus_if.addr); else pass_cnt++;
    total_cnt++; if (bus_if.wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", bus_if.wdata); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_lw();
    tick();
    start = 1'b1; mem_we = 1'b0; mem_funct3 = F3_W; addr = 32'h100;
    #1;
    total_cnt++; if (busy !== 1'b1) $display("FAIL lw_busy_start got %b want 1", busy); else pass_cnt++;
    tick();
    start = 1'b0; bus_if.gnt = 1'b1;
    #1;
    total_cnt++; if (bus_if.req !== 1'b1) $display("FAIL lw_req got %b want 1", bus_if.req); else pass_cnt++;
    total_cnt++; if (bus_if.addr !== 32'h100) $display("FAIL lw_addr got %h want 00000100", bus_if.addr); else pass_cnt++;
    total_cnt++; if (bus_if.be !== 4'hF) $display("FAIL lw_be got %b want 1111", bus_if.be); else pass_cnt++;
    total_cnt++; if (bus_if.we !== 1'b0) $display("FAIL lw_we got %b want 0", bus_if.we); else pass_cnt++;
    tick();
    bus_if.gnt = 1'b0; bus_if.rvalid = 1'b1; bus_if.rdata = 32'hDEADBEEF;
    #1;
    total_cnt++; if (bus_if.req !== 1'b0) $display("FAIL lw_req_wait got %b want 0", bus_if.req); else pass_cnt++;
    total_cnt++; if ({busy, done} !== 2'b10) $display("FAIL lw_wait_busy_done got %b want 10", {busy, done}); else pass_cnt++;
    tick();
    bus_if.rvalid = 1'b0;
    #1;
    total_cnt++; if ({done, err, busy} !== 3'b100) $display("FAIL lw_resp_done_err_busy got %b want 100", {done, err, busy}); else pass_cnt++;
    total_cnt++; if (rdata !== 32'hDEADBEEF) $display("FAIL lw_rdata got %h want deadbeef", rdata); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL lw_done_after got %b want 0", done); else pass_cnt++;
    total_cnt++; if (rdata !== 32'hDEADBEEF) $display("FAIL lw_rdata_held got %h want deadbeef", rdata); else pass_cnt++;
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s   [3];
    logic [31:0] addrs [3];
    logic [31:0] words [3];
    logic [31:0] exps  [3];
    f3s[0] = F3_B;  addrs[0] = 32'h103; words[0] = 32'h80FFFFFF; exps[0] = 32'hFFFFFF80;
    f3s[1] = F3_BU; addrs[1] = 32'h103; words[1] = 32'h80FFFFFF; exps[1] = 32'h00000080;
    f3s[2] = F3_HU; addrs[2] = 32'h102; words[2] = 32'h12345678; exps[2] = 32'h00001234;
    for (int i = 0; i < 3; i++) begin
      tick();
      start = 1'b1; mem_we = 1'b0; mem_funct3 = f3s[i]; addr = addrs[i];
      tick();
      start = 1'b0; bus_if.gnt = 1'b1;
      #1;
      total_cnt++; if (bus_if.addr !== {addrs[i][31:2], 2'b00}) $display("FAIL ext%0d_addr got %h want %h", i, bus_if.addr, {addrs[i][31:2], 2'b00}); else pass_cnt++;
      tick();
      bus_if.gnt = 1'b0; bus_if.rvalid = 1'b1; bus_if.rdata = words[i];
      tick();
      bus_if.rvalid = 1'b0;
      #1;
      total_cnt++; if (done !== 1'b1) $display("FAIL ext%0d_done got %b want 1", i, done); else pass_cnt++;
      total_cnt++; if (rdata !== exps[i]) $display("FAIL ext%0d_rdata got %h want %h", i, rdata, exps[i]); else pass_cnt++;
    end
    tick();
  endtask

  task automatic test_sb_gnt_wait();
    tick();
    start = 1'b1; mem_we = 1'b1; mem_funct3 = F3_B; addr = 32'h201; wdata = 32'h000000AB;
    for (int c = 0; c < 4; c++) begin
      tick();
      start = 1'b0;
      bus_if.gnt = (c == 3);
      #1;
      total_cnt++; if (bus_if.req !== 1'b1) $display("FAIL sb_req_c%0d got %b want 1", c, bus_if.req); else pass_cnt++;
      total_cnt++; if (busy !== 1'b1) $display("FAIL sb_busy_c%0d got %b want 1", c, busy); else pass_cnt++;
      total_cnt++; if ({bus_if.we, bus_if.be} !== 5'b1_0010) $display("FAIL sb_we_be_c%0d got %b want 10010", c, {bus_if.we, bus_if.be}); else pass_cnt++;
      total_cnt++; if (bus_if.addr !== 32'h200) $display("FAIL sb_addr_c%0d got %h want 00000200", c, bus_if.addr); else pass_cnt++;
      total_cnt++; if (bus_if.wdata !== 32'hABABABAB) $display("FAIL sb_wdata_c%0d got %h want abababab", c, bus_if.wdata); else pass_cnt++;
    end
    tick();
    bus_if.gnt = 1'b0;
    #1;
    total_cnt++; if ({done, err, busy, bus_if.req} !== 4'b1000) $display("FAIL sb_resp got %b want 1000", {done, err, busy, bus_if.req}); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (done !== 1'b0) $display("FAIL sb_done_after got %b want 0", done); else pass_cnt++;
  endtask

  task automatic test_illegal();
    logic        wes [2];
    logic [2:0]  f3s [2];
    logic [31:0] ads [2];
    wes[0] = 1'b0; f3s[0] = F3_W;   ads[0] = 32'h102;
    wes[1] = 1'b1; f3s[1] = 3'b011; ads[1] = 32'h100;
    for (int i = 0; i < 2; i++) begin
      tick();
      start = 1'b1; mem_we = wes[i]; mem_funct3 = f3s[i]; addr = ads[i]; wdata = 32'h5A5A5A5A;
      #1;
      total_cnt++; if ({busy, bus_if.req} !== 2'b10) $display("FAIL ill%0d_start_busy_req got %b want 10", i, {busy, bus_if.req}); else pass_cnt++;
      tick();
      start = 1'b0;
      #1;
      total_cnt++; if ({done, err, bus_if.req} !== 3'b110) $display("FAIL ill%0d_done_err_req got %b want 110", i, {done, err, bus_if.req}); else pass_cnt++;
      total_cnt++; if (rdata !== 32'h0) $display("FAIL ill%0d_rdata got %h want 0", i, rdata); else pass_cnt++;
      tick();
      #1;
      total_cnt++; if ({done, err, bus_if.req} !== 3'b000) $display("FAIL ill%0d_after got %b want 000", i, {done, err, bus_if.req}); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    tick();
    start = 1'b1; mem_we = 1'b1; mem_funct3 = F3_W; addr = 32'h300; wdata = 32'h11223344;
    tick();
    start = 1'b0; bus_if.gnt = 1'b1;
    #1;
    total_cnt++; if ({bus_if.be, bus_if.wdata} !== {4'hF, 32'h11223344}) $display("FAIL b2b_sw_be_wdata got %h want f11223344", {bus_if.be, bus_if.wdata}); else pass_cnt++;
    tick();
    bus_if.gnt = 1'b0;
    start = 1'b1; mem_we = 1'b0; mem_funct3 = F3_W; addr = 32'h304;
    #1;
    total_cnt++; if ({done, err, busy} !== 3'b101) $display("FAIL b2b_resp_done_err_busy got %b want 101", {done, err, busy}); else pass_cnt++;
    tick();
    start = 1'b0; bus_if.gnt = 1'b1;
    #1;
    total_cnt++; if ({bus_if.req, bus_if.we, done} !== 3'b100) $display("FAIL b2b_req_we_done got %b want 100", {bus_if.req, bus_if.we, done}); else pass_cnt++;
    total_cnt++; if (bus_if.addr !== 32'h304) $display("FAIL b2b_addr got %h want 00000304", bus_if.addr); else pass_cnt++;
    tick();
    bus_if.gnt = 1'b0; bus_if.rvalid = 1'b1; bus_if.rdata = 32'hCAFEF00D;
    tick();
    bus_if.rvalid = 1'b0;
    #1;
    total_cnt++; if ({done, rdata} !== {1'b1, 32'hCAFEF00D}) $display("FAIL b2b_lw_done_rdata got %h want 1cafef00d", {done, rdata}); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (done_cnt - d0 !== 2) $display("FAIL b2b_done_count got %0d want 2", done_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    tick();
    start = 1'b1; mem_we = 1'b0; mem_funct3 = F3_W; addr = 32'h400;
    tick();
    start = 1'b0; bus_if.gnt = 1'b1;
    tick();
    bus_if.gnt = 1'b0;
    #1;
    total_cnt++; if ({busy, bus_if.req} !== 2'b10) $display("FAIL rmid_wait_busy_req got %b want 10", {busy, bus_if.req}); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0; bus_if.rvalid = 1'b1; bus_if.rdata = 32'h55555555;
    #1;
    total_cnt++; if ({bus_if.req, busy, done} !== 3'b000) $display("FAIL rmid_idle got %b want 000", {bus_if.req, busy, done}); else pass_cnt++;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL rmid_rdata_reset got %h want 0", rdata); else pass_cnt++;
    tick();
    bus_if.rvalid = 1'b0;
    tick();
    tick();
    #1;
    total_cnt++; if (rdata !== 32'h0) $display("FAIL rmid_rdata_late got %h want 0", rdata); else pass_cnt++;
    total_cnt++; if (done_cnt - d0 !== 0) $display("FAIL rmid_done_count got %0d want 0", done_cnt - d0); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; done_cnt = 0;
    rst = 1'b1; start = 1'b0; mem_we = 1'b0; mem_funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = 32'h0;
    test_reset();
    test_lw();
    test_load_extend();
    test_sb_gnt_wait();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
